// File: rtl/sel3_pkg.sv
// rtl/sel3_pkg.sv - shared state encoding, select constants and index-to-one-hot helper
package sel3_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_A    = 3'b001;
    localparam logic [2:0] SEL_B    = 3'b010;
    localparam logic [2:0] SEL_C    = 3'b100;

    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    idx_to_onehot = SEL_A;
            2'd1:    idx_to_onehot = SEL_B;
            2'd2:    idx_to_onehot = SEL_C;
            default: idx_to_onehot = SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational round-robin winner pick among three requesters
module rr_pick3
    import sel3_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_last,
    output logic [2:0] o_win_oh,
    output logic [1:0] o_win_idx,
    output logic       o_win_any
);

    logic [1:0] w_first;
    logic [1:0] w_second;

    assign w_first  = (i_last >= 2'd2) ? 2'd0 : i_last + 2'd1;
    assign w_second = (w_first >= 2'd2) ? 2'd0 : w_first + 2'd1;

    // Scan lowest priority first so the highest-priority match is assigned last.
    always_comb begin
        o_win_idx = 2'd0;
        o_win_any = 1'b0;
        if (i_req[i_last]) begin
            o_win_idx = i_last;
            o_win_any = 1'b1;
        end
        if (i_req[w_second]) begin
            o_win_idx = w_second;
            o_win_any = 1'b1;
        end
        if (i_req[w_first]) begin
            o_win_idx = w_first;
            o_win_any = 1'b1;
        end
    end

    assign o_win_oh = o_win_any ? idx_to_onehot(o_win_idx) : SEL_NONE;

endmodule

// File: rtl/sel3_rr_arb.sv
// rtl/sel3_rr_arb.sv - sticky round-robin arbiter producing the registered 3:1 mux select (option: SEL3_HOLD_LIMIT_EN)
module sel3_rr_arb
    import sel3_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    output logic [2:0]       sl,
    output logic             sl_valid,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (MAX_HOLD < 2 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("sel3_rr_arb: MAX_HOLD out of range for CNT_W");
    end

    state_t           r_state;
    logic [2:0]       r_sl;
    logic             r_sl_valid;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [1:0]       r_last;

    logic [2:0]       w_cand;
    logic [2:0]       w_win_oh;
    logic [1:0]       w_win_idx;
    logic             w_win_any;
    logic             w_keep;
    logic             w_rotate;
    logic             w_hold;

    // The current owner is masked out so a pick always names a different source.
    assign w_cand = req & ~r_sl;

    rr_pick3 u_pick (
        .i_req     (w_cand),
        .i_last    (r_last),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx),
        .o_win_any (w_win_any)
    );

    assign w_keep = (r_state == ST_GRANT) && |(req & r_sl);

`ifdef SEL3_HOLD_LIMIT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    assign w_rotate = w_keep && (r_hold_cnt == HOLD_LAST) && w_win_any;
`else
    assign w_rotate = 1'b0;
`endif

    assign w_hold = w_keep && !w_rotate;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sl       <= SEL_NONE;
            r_sl_valid <= 1'b0;
            r_hold_cnt <= '0;
            r_last     <= 2'd2;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_any) begin
                        r_state    <= ST_GRANT;
                        r_sl       <= w_win_oh;
                        r_sl_valid <= 1'b1;
                        r_hold_cnt <= '0;
                        r_last     <= w_win_idx;
                    end
                end
                ST_GRANT: begin
                    if (w_hold) begin
                        if (r_hold_cnt != CNT_MAX) begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end else if (w_win_any) begin
                        r_sl       <= w_win_oh;
                        r_hold_cnt <= '0;
                        r_last     <= w_win_idx;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_sl       <= SEL_NONE;
                        r_sl_valid <= 1'b0;
                        r_hold_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sl       = r_sl;
    assign sl_valid = r_sl_valid;
    assign hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_sel3_rr_arb.sv
// tb/tb_sel3_rr_arb.sv - directed and randomized self-checking bench for sel3_rr_arb
module tb_sel3_rr_arb;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       req = 3'b000;
    logic [2:0]       sl;
    logic             sl_valid;
    logic [CNT_W-1:0] hold_cnt;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;
    bit run_rand = 1'b0;

    int m_owner = -1;
    int m_last  = 2;
    int m_cnt   = 0;
    int wait_c [3];

    sel3_rr_arb #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .sl       (sl),
        .sl_valid (sl_valid),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_sl();
        return (m_owner < 0) ? 0 : (1 << m_owner);
    endfunction

    // Reference: owner keeps the grant while requesting; otherwise the first requester
    // (other than the owner) scanning last+1, last+2, last wins.
    always @(posedge clk or posedge rst) begin
        logic [2:0] cand;
        int         nxt;
        bit         keep;
        if (rst) begin
            m_owner = -1;
            m_last  = 2;
            m_cnt   = 0;
        end else begin
            keep = (m_owner >= 0) && req[m_owner];
            cand = req;
            if (m_owner >= 0) cand[m_owner] = 1'b0;
`ifdef SEL3_HOLD_LIMIT_EN
            if (keep && m_cnt == MAX_HOLD - 1 && cand != 3'b000) keep = 1'b0;
`endif
            if (keep) begin
                m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            end else begin
                nxt = -1;
                for (int k = 1; k <= 3; k++) begin
                    if (nxt < 0 && cand[(m_last + k) % 3]) nxt = (m_last + k) % 3;
                end
                m_owner = nxt;
                m_cnt   = 0;
                if (nxt >= 0) m_last = nxt;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            chk("cmp_sl", int'(sl), model_sl());
            chk("cmp_sl_valid", int'(sl_valid), int'(m_owner >= 0));
            chk("cmp_hold_cnt", int'(hold_cnt), m_cnt);
            chk("cmp_onehot", int'($countones(sl) <= 1), 1);
        end
    end

`ifdef SEL3_HOLD_LIMIT_EN
    always @(negedge clk) begin
        if (!rst && run_rand) begin
            for (int i = 0; i < 3; i++) begin
                if (req[i] && !sl[i]) wait_c[i]++;
                else wait_c[i] = 0;
                chk("starve_bound", int'(wait_c[i] <= 2 * MAX_HOLD), 1);
            end
        end
    end
`endif

    task automatic step(input logic [2:0] r);
        req = r;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] r;
        int         exp_v;
        repeat (2) @(negedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        chk("rst_sl", int'(sl), 0);
        chk("rst_valid", int'(sl_valid), 0);
        chk("rst_cnt", int'(hold_cnt), 0);
        chk("model_rst_last", m_last, 2);

        step(3'b111); chk("t1_grant_a", int'(sl), 1); chk("t1_cnt0", int'(hold_cnt), 0);
        step(3'b111); chk("t1_cnt1", int'(hold_cnt), 1);
        step(3'b111); chk("t1_cnt2", int'(hold_cnt), 2);
        step(3'b110); chk("t1_switch_b", int'(sl), 2); chk("t1_cnt_clr", int'(hold_cnt), 0);
        chk("model_owner_b", m_owner, 1);
        step(3'b000); chk("t1_idle", int'(sl), 0); chk("t1_idle_valid", int'(sl_valid), 0);

        step(3'b100); chk("t2_grant_c", int'(sl), 4); chk("t2_valid", int'(sl_valid), 1);
        step(3'b000); chk("t2_idle", int'(sl), 0); chk("t2_idle_valid", int'(sl_valid), 0);

        step(3'b100); chk("t3_grant_c", int'(sl), 4);
        step(3'b011); chk("t3_wrap_a", int'(sl), 1);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(3'b011);
`ifdef SEL3_HOLD_LIMIT_EN
            exp_v = ((i / 4) % 2 == 1) ? 2 : 1;
`else
            exp_v = 1;
`endif
            chk("t4_pattern", int'(sl), exp_v);
        end

        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_sl", int'(sl), 0);
        chk("t5_async_valid", int'(sl_valid), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(3'b110); chk("t5_after_rst_b", int'(sl), 2);

        do_reset();
        for (int i = 0; i < 300; i++) step(3'b001);
        chk("t6_saturate", int'(hold_cnt), CNT_MAX);

        do_reset();
        for (int i = 0; i < 3; i++) wait_c[i] = 0;
        run_rand = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            r = req;
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            step(r);
        end
        run_rand = 1'b0;
        cmp_en   = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sel3_rr_arb.md
# sel3_rr_arb

Round-robin arbiter that generates the registered one-hot select `sl[2:0]` driving the 3:1 one-hot mux (`sl[0]`→a, `sl[1]`→b, `sl[2]`→c). It sits directly upstream of the mux, takes one request per mux input and grants one source at a time. Grants are sticky while the owner keeps requesting, with an optional fairness cap on hold length.

## Interface
Parameters:
- `MAX_HOLD`, 4: max consecutive grant cycles before forced rotation (only with `SEL3_HOLD_LIMIT_EN`); legal 2..255.
- `CNT_W`, 8: hold-counter width; `MAX_HOLD` ≤ 2^`CNT_W`−1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  3  request per source; bit0=a, bit1=b, bit2=c.
- `sl`  out  3  registered one-hot select to mux; 3'b000 when idle.
- `sl_valid`  out  1  high when `sl` holds a grant (equals |`sl`).
- `hold_cnt`  out  CNT_W  cycles the current grant has been held, minus 1.

## Operation
- States: IDLE, GRANT. Pointer `last[1:0]` = index of most recently granted source.
- Rotation order from `last`: last+1, last+2, last (mod 3). First requesting source in that order wins.
- IDLE: `sl`=000. Any `req` bit set → next edge grant winner, go GRANT, `hold_cnt`=0, `last`=winner.
- GRANT, owner `g`:
  - `req[g]`=0 and others pending → next edge grant next winner (zero-gap switch), `hold_cnt`=0.
  - `req[g]`=0 and none pending → next edge IDLE, `sl`=000, `hold_cnt`=0; `last` kept.
  - `req[g]`=1 → hold `sl`, `hold_cnt` increments, saturating at 2^`CNT_W`−1.
- `sl` never has more than one bit set; invalid encodings impossible by construction.
- Simultaneous requests: resolved purely by rotation from `last`.
- Requests are sampled, not latched: a request dropped before being granted is forgotten.

## Timing
- Reset (async assert, sync release): `sl`=000, `sl_valid`=0, `hold_cnt`=0, `last`=2 (so source a wins first), state IDLE.
- Reset mid-grant: `sl` drops to 000 immediately, without waiting for a clock.
- Latency req→`sl`: 1 cycle. Release→next grant: 1 cycle, no idle bubble.
- All outputs are registered; no combinational path from `req` to `sl`.

## Configuration
- `SEL3_HOLD_LIMIT_EN` defined: when `hold_cnt` = `MAX_HOLD`−1, `req[g]`=1 and another source is requesting, the next edge rotates to the next winner (`hold_cnt`=0). With no other requester, the owner keeps the grant and the counter continues.
- Not defined: owner holds for as long as `req[g]`=1; `MAX_HOLD` is ignored; `hold_cnt` remains observable.

## Structure
- Shared package `sel3_pkg`: state encoding (IDLE, GRANT), constants SEL_NONE=3'b000, SEL_A=3'b001, SEL_B=3'b010, SEL_C=3'b100, index-to-one-hot function.
- Sub-module `rr_pick3`: combinational winner selection from (`req`, `last`), returning a one-hot winner and its index. The top level holds the FSM, counter and registers.

## Test plan
- Reset then `req`=3'b111 → after 1 edge `sl`=001; hold 3 cycles, drop req[0] → next edge `sl`=010.
- `req`=3'b100 alone from IDLE → `sl`=100 after 1 edge; drop → `sl`=000, `sl_valid`=0 next edge.
- Owner c (`last`=2) releases while `req`=3'b011 → `sl`=001 (wrap-around rotation).
- With `SEL3_HOLD_LIMIT_EN`, `MAX_HOLD`=4, `req`=3'b011 held → `sl`=001 for 4 cycles, then 010 for 4 cycles, alternating. Without the macro → `sl` stays 001.
- Assert `rst` mid-grant between edges → `sl`=000 immediately; after release with `req`=3'b110 → `sl`=010.
- Random `req` for 10k cycles → `sl` always one-hot or zero. No requester starves beyond `MAX_HOLD`×2 cycles when `SEL3_HOLD_LIMIT_EN` is defined.
